// File: rtl/imem_loader.sv
// Byte-stream program loader: unpacks a framed program into sequential 9-bit instruction writes.
// One registered write per INS_HI accept; in_ready is high only while a byte is expected.
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [8:0]            wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_INS_LO = 3'd3;
  localparam logic [2:0] S_INS_HI = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]  state;
  logic [7:0]  len_lo;
  logic [7:0]  ins_lo;
  logic [7:0]  csum;
  logic [12:0] n_total;
  logic [12:0] idx;
  logic [12:0] idx_nxt;
  logic [15:0] len_w;
  logic        accept;

  always_comb begin
    in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_INS_LO) ||
               (state == S_INS_HI) || (state == S_CSUM);
    // The CPU is held exactly while a frame is in flight, which includes CSUM.
    cpu_hold = in_ready;
    accept   = in_valid && in_ready;
    len_w    = {in_data, len_lo};
    idx_nxt  = idx + 13'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      len_lo  <= 8'd0;
      ins_lo  <= 8'd0;
      csum    <= 8'd0;
      n_total <= 13'd0;
      idx     <= 13'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 9'd0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state <= S_LEN_LO;
            done  <= 1'b0;
            error <= 1'b0;
            idx   <= 13'd0;
            csum  <= 8'd0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            // Truncation to 13 bits is safe: anything above DEPTH takes the error path.
            n_total <= len_w[12:0];
            if (len_w > 16'(DEPTH)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else if (len_w == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_INS_LO;
            end
          end
        end
        S_INS_LO: begin
          if (accept) begin
            ins_lo <= in_data;
            csum   <= csum ^ in_data;
            state  <= S_INS_HI;
          end
        end
        S_INS_HI: begin
          if (accept) begin
            if (in_data[7:1] != 7'd0) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_addr <= idx[ADDR_WIDTH-1:0];
              wr_data <= {in_data[0], ins_lo};
              csum    <= csum ^ in_data;
              idx     <= idx_nxt;
              state   <= (idx_nxt == n_total) ? S_CSUM : S_INS_LO;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            if (in_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
